// File: rtl/a_skew_feeder.sv
// rtl/a_skew_feeder.sv - skews A column vectors into per-row delay lines for a systolic PE array.
module a_skew_feeder #(
  parameter int NUM1 = 16,
  parameter int DW   = 32
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               EN,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_last,
  input  logic [NUM1*DW-1:0] in_row,
  output logic [NUM1*DW-1:0] A_left,
  output logic [NUM1-1:0]    lane_valid,
  output logic               busy,
  output logic               done
);

  localparam int CW = $clog2(NUM1) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NUM1 - 1);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            accept;

  always_comb begin
    in_ready = RESET && EN && (state_q == IDLE || state_q == FEED);
    accept   = in_valid && in_ready;
    state_d  = state_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE, FEED: begin
        if (accept) begin
          if (in_last) begin
            state_d = DRAIN;
            cnt_d   = '0;
          end else begin
            state_d = FEED;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == LAST_CNT) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // done is registered so it coincides with the cycle the last element sits on lane NUM1-1
    done_d = (state_d == DRAIN) && (cnt_d == LAST_CNT);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else if (EN) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q && EN;

  // Lane i is i+1 stages deep; bubbles load zero data so invalid lanes always read zero.
  for (genvar i = 0; i < NUM1; i++) begin : g_lane
    logic [DW-1:0] dat_q [i+1];
    logic          vld_q [i+1];

    always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
        for (int j = 0; j <= i; j++) begin
          dat_q[j] <= '0;
          vld_q[j] <= 1'b0;
        end
      end else if (EN) begin
        dat_q[0] <= accept ? in_row[i*DW +: DW] : '0;
        vld_q[0] <= accept;
        for (int j = 1; j <= i; j++) begin
          dat_q[j] <= dat_q[j-1];
          vld_q[j] <= vld_q[j-1];
        end
      end
    end

    assign A_left[i*DW +: DW] = dat_q[i];
    assign lane_valid[i]      = vld_q[i];
  end

endmodule

// File: tb/tb_a_skew_feeder.sv
// tb/tb_a_skew_feeder.sv - directed self-checking bench for a_skew_feeder with NUM1=4, DW=32.
module tb_a_skew_feeder;

  localparam int NUM1 = 4;
  localparam int DW   = 32;

  logic               CLK;
  logic               RESET;
  logic               EN;
  logic               in_valid;
  logic               in_ready;
  logic               in_last;
  logic [NUM1*DW-1:0] in_row;
  logic [NUM1*DW-1:0] A_left;
  logic [NUM1-1:0]    lane_valid;
  logic               busy;
  logic               done;

  int n_chk;
  int n_err;

  logic vin_v  [0:15];
  logic last_v [0:15];
  logic en_v   [0:15];

  a_skew_feeder #(.NUM1(NUM1), .DW(DW)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .EN         (EN),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_last    (in_last),
    .in_row     (in_row),
    .A_left     (A_left),
    .lane_valid (lane_valid),
    .busy       (busy),
    .done       (done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [NUM1*DW-1:0] mkrow(input int v);
    logic [NUM1*DW-1:0] r;
    for (int i = 0; i < NUM1; i++) r[i*DW +: DW] = 32'(v + i);
    return r;
  endfunction

  task automatic clear_vec();
    for (int c = 0; c < 16; c++) begin
      vin_v[c]  = 1'b0;
      last_v[c] = 1'b0;
      en_v[c]   = 1'b1;
    end
  endtask

  // Effective cycle e advances only on enabled edges; lane i shows the vector accepted at e-i.
  task automatic run_seq(input string name, input int n, input int base,
                         input int done_e, input int idle_e, input int last_e);
    int e;
    int k;
    int acc [0:31];
    logic [NUM1*DW-1:0] ea;
    logic [NUM1-1:0]    ev;
    e = -1;
    k = 0;
    for (int a = 0; a < 32; a++) acc[a] = -1;
    for (int c = 0; c < n; c++) begin
      EN       = en_v[c];
      in_valid = vin_v[c];
      in_last  = last_v[c];
      in_row   = vin_v[c] ? mkrow(base + 10*k) : {NUM1{32'hDEAD_BEEF}};
      @(posedge CLK);
      #1;
      if (en_v[c]) begin
        e++;
        if (vin_v[c]) begin
          acc[e] = k;
          k++;
        end
      end
      ea = '0;
      ev = '0;
      for (int i = 0; i < NUM1; i++) begin
        if (e - i >= 0 && acc[e-i] >= 0) begin
          ev[i] = 1'b1;
          ea[i*DW +: DW] = 32'(base + 10*acc[e-i] + i);
        end
      end
      chk($sformatf("%s c%0d A_left", name, c), A_left, ea);
      chk($sformatf("%s c%0d lane_valid", name, c), lane_valid, ev);
      chk($sformatf("%s c%0d busy", name, c), busy, (e >= 0 && e < idle_e));
      chk($sformatf("%s c%0d in_ready", name, c), in_ready,
          en_v[c] && (e < last_e || e >= idle_e));
      chk($sformatf("%s c%0d done", name, c), done, en_v[c] && (e == done_e));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    EN       = 1'b1;
  endtask

  initial begin
    n_chk    = 0;
    n_err    = 0;
    RESET    = 1'b0;
    EN       = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_row   = '0;
    clear_vec();
    repeat (3) @(posedge CLK);
    #1;
    chk("reset A_left", A_left, '0);
    chk("reset lane_valid", lane_valid, '0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset in_ready", in_ready, 0);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    chk("post-reset in_ready", in_ready, 1);

    // back-to-back: k=0..3 accepted on consecutive edges, last on k=3
    clear_vec();
    for (int c = 0; c < 4; c++) vin_v[c] = 1'b1;
    last_v[3] = 1'b1;
    run_seq("b2b", 9, 0, 6, 7, 3);

    // two-cycle bubble between vectors 0 and 1
    clear_vec();
    vin_v[0] = 1'b1;
    vin_v[3] = 1'b1;
    vin_v[4] = 1'b1;
    vin_v[5] = 1'b1;
    last_v[5] = 1'b1;
    run_seq("bubble", 11, 0, 8, 9, 5);

    // single-vector tile
    clear_vec();
    vin_v[0]  = 1'b1;
    last_v[0] = 1'b1;
    run_seq("single", 6, 100, 3, 4, 0);

    // EN low for 3 cycles mid-DRAIN
    clear_vec();
    vin_v[0]  = 1'b1;
    last_v[0] = 1'b1;
    en_v[2]   = 1'b0;
    en_v[3]   = 1'b0;
    en_v[4]   = 1'b0;
    run_seq("freeze", 9, 200, 3, 4, 0);

    // reset with two vectors in flight
    clear_vec();
    vin_v[0] = 1'b1;
    vin_v[1] = 1'b1;
    run_seq("prereset", 2, 50, 99, 99, 99);
    RESET = 1'b0;
    #1;
    chk("midreset A_left", A_left, '0);
    chk("midreset lane_valid", lane_valid, '0);
    chk("midreset busy", busy, 0);
    chk("midreset done", done, 0);
    chk("midreset in_ready", in_ready, 0);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    clear_vec();
    vin_v[0]  = 1'b1;
    last_v[0] = 1'b1;
    run_seq("postreset", 6, 300, 3, 4, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
